// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI-flash responder.
//   ADDR_W        : width of the local memory byte address
//   OP_*          : supported opcodes (READ, FAST READ, JEDEC ID)
//   JEDEC_*       : manufacturer / type / capacity ID bytes
//   MISO_IDLE     : level driven on MISO when no data bit is presented
//   state_t       : responder FSM states
//   jedec_byte()  : ID byte by index, 0xFF past the last ID byte
package spi_flash_pkg;

  localparam int ADDR_W = 22;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_JEDEC_ID  = 8'h9F;

  localparam logic [7:0] JEDEC_MFR  = 8'hEF;
  localparam logic [7:0] JEDEC_TYPE = 8'h40;
  localparam logic [7:0] JEDEC_CAP  = 8'h16;

  localparam logic MISO_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_ID,
    ST_IGNORE
  } state_t;

  function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = JEDEC_MFR;
      2'd1:    b = JEDEC_TYPE;
      2'd2:    b = JEDEC_CAP;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer with registered rise/fall strobes.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   din   : asynchronous pin
//   sync  : synchronized level (2 clocks after the pin)
//   rise  : one-cycle strobe, 3 clocks after a pin rising edge
//   fall  : one-cycle strobe, 3 clocks after a pin falling edge
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= RESET_VAL;
      s2   <= RESET_VAL;
      s3   <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign sync = s2;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI-flash responder (W25Q32 subset) serving bytes from a local memory port.
//   MCLK, nRESET        : system clock, async active-low reset
//   nCS, CLK, MOSI      : SPI pins from the master (mode 0), oversampled
//   MISO                : serial data to the master, 1 when idle
//   MEMADDR, MEMRDREQ   : byte read request, held until MEMRDACK
//   MEMRDACK, MEMDATA   : one-cycle acknowledge with data
//   BUSY                : synchronized nCS low
//   CMDERR, UNDERRUN    : sticky error flags, cleared only by reset
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | nCS high, waiting for a transaction
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in the 24-bit address
// ST_DUMMY  | FAST READ dummy byte, MISO held at 1
// ST_DATA   | streaming memory bytes, prefetching one byte ahead
// ST_ID     | streaming JEDEC ID bytes, then 0xFF
// ST_IGNORE | unsupported opcode, MISO held at 1 until nCS high
module spi_flash_responder
  import spi_flash_pkg::*;
(
  input  logic              MCLK,
  input  logic              nRESET,
  input  logic              nCS,
  input  logic              CLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic [ADDR_W-1:0] MEMADDR,
  output logic              MEMRDREQ,
  input  logic              MEMRDACK,
  input  logic [7:0]        MEMDATA,
  output logic              BUSY,
  output logic              CMDERR,
  output logic              UNDERRUN
);

  logic clk_rise, clk_fall, clk_lvl_unused;
  logic ncs_sync, ncs_rise_unused, ncs_fall_unused;
  logic mosi_s1, mosi_s2;

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt;
  logic [20:0] sr_in;
  logic [6:0]  sr_out;
  logic        is_fast;
  logic [1:0]  id_idx;
  logic [7:0]  pf;
  logic        pf_vld;
  logic [1:0]  skip;

  logic       cs_on;
  logic [7:0] cmd_byte;
  logic       start_read, load_addr, cmd_end, ack_ok;
  logic       boundary, take_pf, bypass, underrun_ev, pf_fill, ack_drop;
  logic [7:0] byte_src;

  spi_edge_sync #(.RESET_VAL(1'b0)) u_clk_sync (
    .clk   (MCLK),
    .rst_n (nRESET),
    .din   (CLK),
    .sync  (clk_lvl_unused),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  spi_edge_sync #(.RESET_VAL(1'b1)) u_ncs_sync (
    .clk   (MCLK),
    .rst_n (nRESET),
    .din   (nCS),
    .sync  (ncs_sync),
    .rise  (ncs_rise_unused),
    .fall  (ncs_fall_unused)
  );

  assign cs_on    = ~ncs_sync;
  assign BUSY     = cs_on;
  assign cmd_byte = {sr_in[6:0], mosi_s2};

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!cs_on) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_CMD;
        ST_CMD:
          if (clk_rise && bit_cnt == 5'd7) begin
            case (cmd_byte)
              OP_READ, OP_FAST_READ: state_nxt = ST_ADDR;
              OP_JEDEC_ID:           state_nxt = ST_ID;
              default:               state_nxt = ST_IGNORE;
            endcase
          end
        ST_ADDR:
          if (clk_rise && bit_cnt == 5'd23) state_nxt = is_fast ? ST_DUMMY : ST_DATA;
        ST_DUMMY:
          if (clk_rise && bit_cnt == 5'd7) state_nxt = ST_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  // Memory-side bookkeeping. "skip" counts byte slots already sent as 0xFF
  // whose memory read is still in flight; those acks are discarded so the
  // stream stays aligned with the address.
  always_comb begin
    cmd_end     = cs_on && clk_rise && state == ST_CMD && bit_cnt == 5'd7;
    load_addr   = cs_on && clk_rise && state == ST_ADDR && bit_cnt == 5'd23;
    start_read  = state != ST_DATA && state_nxt == ST_DATA;
    ack_ok      = MEMRDACK && MEMRDREQ && cs_on && state == ST_DATA;
    boundary    = cs_on && clk_fall && state == ST_DATA && bit_cnt == 5'd0;
    take_pf     = boundary && pf_vld;
    bypass      = boundary && !pf_vld && ack_ok && skip == 2'd0;
    underrun_ev = boundary && !pf_vld && !bypass;
    ack_drop    = ack_ok && skip != 2'd0;
    pf_fill     = ack_ok && skip == 2'd0 && !bypass;
    byte_src    = 8'hFF;
    if (state == ST_ID)  byte_src = jedec_byte(id_idx);
    else if (pf_vld)     byte_src = pf;
    else if (bypass)     byte_src = MEMDATA;
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      bit_cnt  <= '0;
      sr_in    <= '0;
      sr_out   <= '1;
      is_fast  <= 1'b0;
      id_idx   <= '0;
      MISO     <= MISO_IDLE;
      MEMADDR  <= '0;
      MEMRDREQ <= 1'b0;
      pf       <= '0;
      pf_vld   <= 1'b0;
      skip     <= '0;
      CMDERR   <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;

      if (!cs_on || state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (clk_rise) begin
        if (state_nxt != state)
          bit_cnt <= '0;
        else if (state == ST_DATA || state == ST_ID)
          bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
        else
          bit_cnt <= bit_cnt + 5'd1;
      end

      if (clk_rise && (state == ST_CMD || state == ST_ADDR))
        sr_in <= {sr_in[19:0], mosi_s2};

      if (cmd_end) begin
        is_fast <= (cmd_byte == OP_FAST_READ);
        if (state_nxt == ST_IGNORE) CMDERR <= 1'b1;
      end

      if (load_addr) MEMADDR <= {sr_in[20:0], mosi_s2};
      else if (ack_ok) MEMADDR <= MEMADDR + 1'b1;

      if (!cs_on || ack_ok)
        MEMRDREQ <= 1'b0;
      else if (start_read || (state == ST_DATA && !MEMRDREQ && !pf_vld))
        MEMRDREQ <= 1'b1;

      if (!cs_on) begin
        pf_vld <= 1'b0;
      end else if (pf_fill) begin
        pf     <= MEMDATA;
        pf_vld <= 1'b1;
      end else if (take_pf) begin
        pf_vld <= 1'b0;
      end

      if (!cs_on) skip <= '0;
      else if (underrun_ev && !ack_drop && skip != 2'd3) skip <= skip + 2'd1;
      else if (ack_drop && !underrun_ev) skip <= skip - 2'd1;

      if (underrun_ev) UNDERRUN <= 1'b1;

      if (!cs_on) begin
        id_idx <= '0;
        MISO   <= MISO_IDLE;
      end else if (clk_fall) begin
        if ((state == ST_DATA || state == ST_ID) && bit_cnt == 5'd0) begin
          sr_out <= byte_src[6:0];
          MISO   <= byte_src[7];
          if (state == ST_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
        end else if (state == ST_DATA || state == ST_ID) begin
          sr_out <= {sr_out[5:0], 1'b1};
          MISO   <= sr_out[6];
        end else begin
          MISO <= MISO_IDLE;
        end
      end
    end
  end

endmodule
